// File: rtl/arrow_nn_pkg.sv
// Shared definitions for the arrow classifier slice.
//  - Arrow class index constants (one-hot bit positions of the classifier output).
//  - score_w(): width of a signed frame score able to hold +/- w*h.
//  - delta_w(): width of a signed per-row score delta able to hold +/- w.
//  - state_t: classifier FSM state encoding.
package arrow_nn_pkg;

  localparam int unsigned UP        = 0;
  localparam int unsigned UPLEFT    = 1;
  localparam int unsigned LEFTDOWN  = 2;
  localparam int unsigned LEFT      = 3;
  localparam int unsigned DOWN      = 4;
  localparam int unsigned UPRIGHT   = 5;
  localparam int unsigned DOWNRIGHT = 6;
  localparam int unsigned RIGHT     = 7;

  function automatic int unsigned score_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h + 1) + 1;
  endfunction

  function automatic int unsigned delta_w(input int unsigned w);
    return $clog2(w + 1) + 1;
  endfunction

  typedef enum logic [1:0] {
    S_ACC,
    S_ARG,
    S_OUT
  } state_t;

endpackage

// File: rtl/arrow_row_scorer.sv
// Combinational signed match score of one pixel row against one mask row.
//  delta = popcnt(row & mask) - popcnt(row & ~mask); unset pixels contribute nothing.
// Ports:
//  row    in   W       pixel row
//  mask   in   W       mask row
//  delta  out  DW      signed delta in [-W, +W]
module arrow_row_scorer
  import arrow_nn_pkg::*;
#(
  parameter  int unsigned W  = 16,
  localparam int unsigned DW = delta_w(W)
) (
  input  logic [W-1:0]         row,
  input  logic [W-1:0]         mask,
  output logic signed [DW-1:0] delta
);

  always_comb begin
    delta = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (row[i]) begin
        delta = mask[i] ? delta + DW'(1) : delta - DW'(1);
      end
    end
  end

endmodule

// File: rtl/arrow_classifier_seq.sv
// Streaming template-match classifier.
//  Accepts an IMG_H x IMG_W binary frame one row per beat, scores it against
//  N_CLASSES run-time-loadable masks and returns the arg-max class (one-hot,
//  index and signed score). Ties go to the lowest class index.
// Optional feature macro: ARROW_THRESH_EN -- when defined, a winning score
//  below THRESHOLD reports out_onehot=0 (UNKNOWN); idx/score still report the
//  best candidate.
// Ports:
//  clk, rst_n                      clock (rising edge), async active-low reset
//  in_valid/in_ready/in_row        row stream, MSB = leftmost pixel, top row first
//  mask_we/mask_class/mask_row/
//  mask_data                       mask row write port (ignored while mask_busy)
//  mask_busy                       high while a frame or result is in progress
//  out_valid/out_ready             result handshake, result held until accepted
//  out_onehot/out_idx/out_score    winning class one-hot, index, signed score
module arrow_classifier_seq
  import arrow_nn_pkg::*;
#(
  parameter  int unsigned IMG_W     = 16,
  parameter  int unsigned IMG_H     = 16,
  parameter  int unsigned N_CLASSES = 8,
  parameter  int          THRESHOLD = 0,
  localparam int unsigned SCORE_W   = score_w(IMG_W, IMG_H)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IMG_W-1:0]             in_row,
  input  logic                         mask_we,
  input  logic [$clog2(N_CLASSES)-1:0] mask_class,
  input  logic [$clog2(IMG_H)-1:0]     mask_row,
  input  logic [IMG_W-1:0]             mask_data,
  output logic                         mask_busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_CLASSES-1:0]         out_onehot,
  output logic [$clog2(N_CLASSES)-1:0] out_idx,
  output logic signed [SCORE_W-1:0]    out_score
);

  localparam int unsigned CW = $clog2(N_CLASSES);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned KW = $clog2(N_CLASSES + 1);
  localparam int unsigned DW = delta_w(IMG_W);
  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t                    state;
  logic [RW-1:0]             row_cnt;
  logic [KW-1:0]             k;
  logic signed [SCORE_W-1:0] best_score;
  logic [CW-1:0]             best_idx;
  logic signed [SCORE_W-1:0] scores [N_CLASSES];
  logic [IMG_W-1:0]          masks  [N_CLASSES][IMG_H];
  logic signed [DW-1:0]      deltas [N_CLASSES];
  logic [N_CLASSES-1:0]      onehot_nxt;

  for (genvar c = 0; c < N_CLASSES; c++) begin : g_scorer
    arrow_row_scorer #(.W(IMG_W)) u_scorer (
      .row   (in_row),
      .mask  (masks[c][row_cnt]),
      .delta (deltas[c])
    );
  end

`ifdef ARROW_THRESH_EN
  localparam logic signed [SCORE_W-1:0] THRESH_S = SCORE_W'(THRESHOLD);

  always_comb begin
    onehot_nxt = '0;
    onehot_nxt[best_idx] = 1'b1;
    if (best_score < THRESH_S) onehot_nxt = '0;
  end
`else
  logic [31:0] unused_threshold;
  assign unused_threshold = THRESHOLD;

  always_comb begin
    onehot_nxt = '0;
    onehot_nxt[best_idx] = 1'b1;
  end
`endif

  // Mask store; a write issued together with the first row lands after that
  // row has been scored with the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CLASSES; c++)
        for (int unsigned r = 0; r < IMG_H; r++)
          masks[c][r] <= '0;
    end else if (mask_we && !mask_busy) begin
      masks[mask_class][mask_row] <= mask_data;
    end
  end

  // k runs 0..N_CLASSES-1 comparing, then one extra step (k==N_CLASSES)
  // publishes the result, giving N_CLASSES+1 cycles from last row to out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ACC;
      row_cnt    <= '0;
      k          <= '0;
      best_score <= '0;
      best_idx   <= '0;
      for (int unsigned c = 0; c < N_CLASSES; c++) scores[c] <= '0;
      in_ready   <= 1'b1;
      mask_busy  <= 1'b0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_idx    <= '0;
      out_score  <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            for (int unsigned c = 0; c < N_CLASSES; c++)
              scores[c] <= scores[c] + SCORE_W'(deltas[c]);
            mask_busy <= 1'b1;
            if (row_cnt == RW'(IMG_H - 1)) begin
              state      <= S_ARG;
              row_cnt    <= '0;
              in_ready   <= 1'b0;
              k          <= '0;
              best_score <= MOST_NEG;
              best_idx   <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        S_ARG: begin
          if (k == KW'(N_CLASSES)) begin
            state      <= S_OUT;
            out_valid  <= 1'b1;
            out_onehot <= onehot_nxt;
            out_idx    <= best_idx;
            out_score  <= best_score;
          end else begin
            if (scores[k[CW-1:0]] > best_score) begin
              best_score <= scores[k[CW-1:0]];
              best_idx   <= k[CW-1:0];
            end
            k <= k + KW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            mask_busy <= 1'b0;
            row_cnt   <= '0;
            for (int unsigned c = 0; c < N_CLASSES; c++) scores[c] <= '0;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule
